identification_frame_scheduler: RTL and testbench
=================================================

# identification_frame_scheduler

Sequences the output side of the pulse identification stage. Once identification completes, it latches the polynomial and per-sensor iteration results and serialises them as a fixed byte frame over a valid/ready byte link toward the host transmitter. It then releases the identifier by pulsing its `reset` input. A backpressure watchdog ensures a stalled link never deadlocks the identification pipeline.

## Interface
Parameters:
- `SENSOR_NB`, default 4: number of iteration words sent per frame (1..8).
- `TIMEOUT_TICKS`, default 72000: maximum cycles `tx_ready` may stay low with `tx_valid` high before the frame is aborted (~1 ms at 72 MHz).
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.

Ports:
- `clk_72MHz` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `id_ready` in 1: identification result valid; from the identifier's `ready`.
- `id_polynomial` in 17: identified polynomial.
- `id_iteration_0` … `id_iteration_7` in 17 each: per-sensor iteration offsets. Indices ≥ `SENSOR_NB` are ignored.
- `id_reset` out 1: acknowledge/release to the identifier's `reset`.
- `tx_data` out 8: frame byte.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: sink accepts the byte when `tx_valid` and `tx_ready` are both high.
- `busy` out 1: high in any state other than IDLE.
- `frames_sent` out 16: count of completed frames; wraps.
- `frames_dropped` out 8: count of aborted frames; saturates at 255.

## Operation
- States: IDLE, LATCH, SEND, RELEASE.
- **IDLE:**
  - When `id_ready` = 1, go to LATCH.
  - `id_ready` arriving while not in IDLE is not queued. The identifier holds `ready` until it is released, so no event is lost.
- **LATCH:**
  - Copy the polynomial and iterations 0..`SENSOR_NB`-1 into a shadow register file.
  - Clear the byte index and the watchdog.
  - Go to SEND.
- **SEND:** drive the byte at the current index.
  - Frame order:
    - `SYNC_BYTE`.
    - Polynomial zero-extended to 24 bits, MSB first: 3 bytes.
    - For each sensor k = 0..`SENSOR_NB`-1: iteration_k zero-extended to 24 bits, MSB first: 3 bytes.
  - Frame length L = 4 + 3·`SENSOR_NB`. The default is 16 bytes.
  - On handshake, the index increments.
  - On handshake of byte L-1:
    - `frames_sent` increments.
    - Go to RELEASE.
  - Watchdog:
    - Counts each cycle that `tx_valid` = 1 and `tx_ready` = 0.
    - Clears on every handshake.
  - Timeout: when the watchdog reaches `TIMEOUT_TICKS`:
    - Drop `tx_valid`.
    - `frames_dropped` increments, saturating.
    - Go to RELEASE.
- **RELEASE:**
  - Hold `id_reset` = 1 while `id_ready` = 1.
  - On the first cycle with `id_ready` sampled 0, deassert `id_reset` and go to IDLE.
- A completed frame and an aborted frame release the identifier identically.
- **Reset:**
  - Any state goes to IDLE.
  - The shadow registers, byte index and watchdog clear.
  - A frame in flight is discarded without incrementing either counter.

## Timing
- All outputs are registered.
- Reset values:
  - `tx_valid` = 0, `tx_data` = 0, `id_reset` = 0, `busy` = 0.
  - `frames_sent` = 0, `frames_dropped` = 0.
- `id_ready` rising in IDLE at cycle N:
  - LATCH at N+1.
  - First `tx_valid` with `SYNC_BYTE` at N+2.
- Byte stream rules:
  - With `tx_ready` held high, one byte per cycle and no bubbles.
  - `tx_data` is stable while `tx_valid` = 1 and `tx_ready` = 0.
  - `tx_valid` never drops without a handshake, except on timeout or reset.
- `id_reset` rises the cycle after the last handshake or the timeout cycle.
- `id_reset` falls the cycle after `id_ready` is seen low.
- IDLE is re-entered together with that `id_reset` fall. A new `id_ready` is accepted the next cycle.
- Input changes after LATCH do not affect the frame.
- Simultaneous last handshake and watchdog expiry:
  - The handshake wins.
  - The frame counts as sent, not dropped.

## Configuration
- `ID_FRAME_CRC_EN`:
  - Defined: append one CRC-8 byte, making L = 5 + 3·`SENSOR_NB`.
    - Polynomial 0x07, init 0x00, no reflection, no final XOR.
    - Computed over all preceding frame bytes including `SYNC_BYTE`.
    - Updated on each handshake.
  - Undefined: no CRC logic or byte; L = 4 + 3·`SENSOR_NB`.

## Structure
- Shared package (`id_frame_pkg`):
  - State encoding constants.
  - `SYNC_BYTE` default.
  - Word width 17 and padded width 24.
  - The L formula as a constant function of `SENSOR_NB` and the CRC macro.
- Sub-module `crc8_update`, present only under `ID_FRAME_CRC_EN`:
  - Combinational next-CRC from (crc, byte).
  - Registered in the parent on handshake.

## Test plan
- **Basic frame:** `id_ready` = 1, poly = 17'h1ABCD, iterations 0..3 = 1, 2, 3, 17'h1FFFF, `tx_ready` = 1.
  - Bytes: A5 01 AB CD 00 00 01 00 00 02 00 00 03 01 FF FF.
  - Then `id_reset` = 1 until `id_ready` drops.
  - `frames_sent` = 1.
- **Backpressure:** `tx_ready` toggles every other cycle.
  - Identical bytes, each held stable while stalled.
  - No duplicates or skips.
- **Timeout:** `tx_ready` = 0 forever, `TIMEOUT_TICKS` = 16.
  - `tx_valid` drops after 16 stalled cycles.
  - `frames_dropped` = 1; `id_reset` asserts.
  - Drive 300 timeouts: `frames_dropped` saturates at 255.
- **Reset mid-frame:** `reset` after byte 5.
  - Next cycle: `tx_valid` = 0, `busy` = 0, both counters unchanged.
  - Next `id_ready` restarts with `SYNC_BYTE`.
- **CRC build:** with `ID_FRAME_CRC_EN`, the basic frame appends the 17th byte, equal to CRC-8/0x07 of the 16 prior bytes per the reference model.
- **Simultaneity:** last handshake on the exact watchdog expiry cycle.
  - `frames_sent` increments, `frames_dropped` unchanged.

Source files
------------

// File: rtl/id_frame_pkg.sv
// Shared types and constants for the identification frame scheduler.
// Frame length depends on the ID_FRAME_CRC_EN build macro.
package id_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATCH   = 2'd1,
        SEND    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned WORD_W            = 17;
    localparam int unsigned PAD_W             = 24;
    localparam int unsigned MAX_SENSORS       = 8;

    // SYNC + polynomial + one padded word per sensor (+ CRC byte)
    function automatic int unsigned frame_len(input int unsigned sensor_nb);
`ifdef ID_FRAME_CRC_EN
        return 5 + 3 * sensor_nb;
`else
        return 4 + 3 * sensor_nb;
`endif
    endfunction

endpackage

// File: rtl/identification_frame_scheduler_crc8_update.sv
// Combinational CRC-8 step (poly 0x07, MSB first); built only with ID_FRAME_CRC_EN.
`ifdef ID_FRAME_CRC_EN
module crc8_update (
    input  logic [7:0] i_crc,
    input  logic [7:0] i_byte,
    output logic [7:0] o_crc
);

    logic [7:0] w_c;

    always_comb begin
        w_c = i_crc ^ i_byte;
        for (int unsigned b = 0; b < 8; b++) begin
            w_c = w_c[7] ? ((w_c << 1) ^ 8'h07) : (w_c << 1);
        end
        o_crc = w_c;
    end

endmodule
`endif

// File: rtl/identification_frame_scheduler.sv
// Latches identification results, streams them as a byte frame, then releases the identifier.
// Optional trailing CRC-8 byte under the ID_FRAME_CRC_EN macro.
module identification_frame_scheduler
    import id_frame_pkg::*;
#(
    parameter int unsigned SENSOR_NB     = 4,
    parameter int unsigned TIMEOUT_TICKS = 72000,
    parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
    input  logic              clk_72MHz,
    input  logic              reset,
    input  logic              id_ready,
    input  logic [WORD_W-1:0] id_polynomial,
    input  logic [WORD_W-1:0] id_iteration_0,
    input  logic [WORD_W-1:0] id_iteration_1,
    input  logic [WORD_W-1:0] id_iteration_2,
    input  logic [WORD_W-1:0] id_iteration_3,
    input  logic [WORD_W-1:0] id_iteration_4,
    input  logic [WORD_W-1:0] id_iteration_5,
    input  logic [WORD_W-1:0] id_iteration_6,
    input  logic [WORD_W-1:0] id_iteration_7,
    output logic              id_reset,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [15:0]       frames_sent,
    output logic [7:0]        frames_dropped
);

    localparam int unsigned      FRAME_LEN = frame_len(SENSOR_NB);
    localparam int unsigned      IDX_W     = $clog2(FRAME_LEN);
    localparam int unsigned      WDOG_W    = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_TICKS - 1);

    state_t            r_state, w_state_next;
    logic [WORD_W-1:0] r_poly;
    logic [WORD_W-1:0] r_iter [SENSOR_NB];
    logic [IDX_W-1:0]  r_idx, w_idx_next;
    logic [WDOG_W-1:0] r_wdog, w_wdog_next;
    logic              r_tx_valid, w_tx_valid_next;
    logic [7:0]        r_tx_data, w_tx_data_next;
    logic              r_id_reset, w_id_reset_next;
    logic              r_busy;
    logic [15:0]       r_sent, w_sent_next;
    logic [7:0]        r_dropped, w_dropped_next;

    logic [WORD_W-1:0] w_iter_in [MAX_SENSORS];
    logic [7:0]        w_frame [FRAME_LEN];
    logic [PAD_W-1:0]  w_pad;
    logic [7:0]        w_next_byte;
    logic              w_handshake;
    logic              w_unused_iters;

    assign w_iter_in[0] = id_iteration_0;
    assign w_iter_in[1] = id_iteration_1;
    assign w_iter_in[2] = id_iteration_2;
    assign w_iter_in[3] = id_iteration_3;
    assign w_iter_in[4] = id_iteration_4;
    assign w_iter_in[5] = id_iteration_5;
    assign w_iter_in[6] = id_iteration_6;
    assign w_iter_in[7] = id_iteration_7;
    assign w_unused_iters = ^{w_iter_in[0], w_iter_in[1], w_iter_in[2], w_iter_in[3],
                              w_iter_in[4], w_iter_in[5], w_iter_in[6], w_iter_in[7]};

    assign w_handshake = r_tx_valid & tx_ready;

`ifdef ID_FRAME_CRC_EN
    logic [7:0] r_crc, w_crc_next, w_crc_upd;

    crc8_update u_crc8_update (
        .i_crc  (r_crc),
        .i_byte (r_tx_data),
        .o_crc  (w_crc_upd)
    );
`endif

    // Whole frame laid out from the shadow registers; the CRC slot takes the running CRC
    // including the byte currently being handed over.
    always_comb begin
        for (int unsigned j = 0; j < FRAME_LEN; j++) w_frame[j] = '0;
        w_frame[0] = SYNC_BYTE;
        w_pad      = PAD_W'(r_poly);
        w_frame[1] = w_pad[23:16];
        w_frame[2] = w_pad[15:8];
        w_frame[3] = w_pad[7:0];
        for (int unsigned k = 0; k < SENSOR_NB; k++) begin
            w_pad              = PAD_W'(r_iter[k]);
            w_frame[4 + 3 * k] = w_pad[23:16];
            w_frame[5 + 3 * k] = w_pad[15:8];
            w_frame[6 + 3 * k] = w_pad[7:0];
        end
`ifdef ID_FRAME_CRC_EN
        w_frame[FRAME_LEN - 1] = w_crc_upd;
`endif
        w_next_byte = (r_idx == LAST_IDX) ? '0 : w_frame[r_idx + 1'b1];
    end

    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_wdog_next     = r_wdog;
        w_tx_valid_next = r_tx_valid;
        w_tx_data_next  = r_tx_data;
        w_id_reset_next = r_id_reset;
        w_sent_next     = r_sent;
        w_dropped_next  = r_dropped;
`ifdef ID_FRAME_CRC_EN
        w_crc_next      = r_crc;
`endif
        case (r_state)
            IDLE: if (id_ready) w_state_next = LATCH;
            LATCH: begin
                w_idx_next      = '0;
                w_wdog_next     = '0;
                w_tx_valid_next = 1'b1;
                w_tx_data_next  = SYNC_BYTE;
`ifdef ID_FRAME_CRC_EN
                w_crc_next      = '0;
`endif
                w_state_next    = SEND;
            end
            SEND: begin
                // A handshake always takes priority over watchdog expiry
                if (w_handshake) begin
                    w_wdog_next = '0;
`ifdef ID_FRAME_CRC_EN
                    w_crc_next  = w_crc_upd;
`endif
                    if (r_idx == LAST_IDX) begin
                        w_tx_valid_next = 1'b0;
                        w_sent_next     = r_sent + 16'd1;
                        w_id_reset_next = 1'b1;
                        w_state_next    = RELEASE;
                    end else begin
                        w_idx_next     = r_idx + 1'b1;
                        w_tx_data_next = w_next_byte;
                    end
                end else if (r_tx_valid) begin
                    if (r_wdog == WDOG_LAST) begin
                        w_tx_valid_next = 1'b0;
                        if (r_dropped != 8'hFF) w_dropped_next = r_dropped + 8'd1;
                        w_id_reset_next = 1'b1;
                        w_state_next    = RELEASE;
                    end else begin
                        w_wdog_next = r_wdog + 1'b1;
                    end
                end
            end
            RELEASE: begin
                if (!id_ready) begin
                    w_id_reset_next = 1'b0;
                    w_state_next    = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_72MHz) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_wdog     <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_id_reset <= 1'b0;
            r_busy     <= 1'b0;
            r_sent     <= '0;
            r_dropped  <= '0;
            r_poly     <= '0;
            for (int unsigned k = 0; k < SENSOR_NB; k++) r_iter[k] <= '0;
`ifdef ID_FRAME_CRC_EN
            r_crc      <= '0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_wdog     <= w_wdog_next;
            r_tx_valid <= w_tx_valid_next;
            r_tx_data  <= w_tx_data_next;
            r_id_reset <= w_id_reset_next;
            r_busy     <= (w_state_next != IDLE);
            r_sent     <= w_sent_next;
            r_dropped  <= w_dropped_next;
            if (r_state == LATCH) begin
                r_poly <= id_polynomial;
                for (int unsigned k = 0; k < SENSOR_NB; k++) r_iter[k] <= w_iter_in[k];
            end
`ifdef ID_FRAME_CRC_EN
            r_crc      <= w_crc_next;
`endif
        end
    end

    assign id_reset       = r_id_reset;
    assign tx_data        = r_tx_data;
    assign tx_valid       = r_tx_valid;
    assign busy           = r_busy;
    assign frames_sent    = r_sent;
    assign frames_dropped = r_dropped;

endmodule

// File: tb/tb_identification_frame_scheduler.sv
// Directed self-checking bench for identification_frame_scheduler (SENSOR_NB=4, TIMEOUT_TICKS=16).
module tb_identification_frame_scheduler;
    import id_frame_pkg::*;

    localparam int unsigned NS = 4;
    localparam int unsigned TO = 16;
    localparam int unsigned L  = frame_len(NS);

    logic        clk_72MHz = 1'b0;
    logic        reset     = 1'b1;
    logic        id_ready  = 1'b0;
    logic        tx_ready  = 1'b0;
    logic [16:0] id_polynomial;
    logic [16:0] id_iteration_0, id_iteration_1, id_iteration_2, id_iteration_3;
    logic [16:0] id_iteration_4, id_iteration_5, id_iteration_6, id_iteration_7;
    logic        id_reset, tx_valid, busy;
    logic [7:0]  tx_data, frames_dropped;
    logic [15:0] frames_sent;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_frame[$];
    logic [7:0]  got[$];

    always #7 clk_72MHz = ~clk_72MHz;

    identification_frame_scheduler #(
        .SENSOR_NB     (NS),
        .TIMEOUT_TICKS (TO)
    ) dut (
        .clk_72MHz      (clk_72MHz),
        .reset          (reset),
        .id_ready       (id_ready),
        .id_polynomial  (id_polynomial),
        .id_iteration_0 (id_iteration_0),
        .id_iteration_1 (id_iteration_1),
        .id_iteration_2 (id_iteration_2),
        .id_iteration_3 (id_iteration_3),
        .id_iteration_4 (id_iteration_4),
        .id_iteration_5 (id_iteration_5),
        .id_iteration_6 (id_iteration_6),
        .id_iteration_7 (id_iteration_7),
        .id_reset       (id_reset),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .busy           (busy),
        .frames_sent    (frames_sent),
        .frames_dropped (frames_dropped)
    );

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic step;
        @(posedge clk_72MHz);
        #1;
    endtask

    // Bit-serial reference CRC-8, poly 0x07, init 0
    function automatic logic [7:0] crc_ref(input logic [7:0] q[$]);
        logic [7:0] c = 8'h00;
        logic       fb;
        foreach (q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ q[i][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    task automatic set_inputs;
        id_polynomial  = 17'h1ABCD;
        id_iteration_0 = 17'h00001;
        id_iteration_1 = 17'h00002;
        id_iteration_2 = 17'h00003;
        id_iteration_3 = 17'h1FFFF;
        id_iteration_4 = 17'h15555;
        id_iteration_5 = 17'h0AAAA;
        id_iteration_6 = 17'h12345;
        id_iteration_7 = 17'h1F0F0;
    endtask

    // mode 0: ready always high; 1: ready toggles; 2: last byte stalled TO-1 cycles then accepted
    task automatic run_frame(input int mode, input string tag);
        int   cyc = 0;
        int   stall_cnt = 0;
        logic stalled = 1'b0;
        logic rdy;
        logic [7:0] prev_data = 8'h00;
        got.delete();
        id_ready = 1'b1;
        while (!id_reset && cyc < 400) begin
            step();
            cyc++;
            if (stalled) check({tag, "_hold"}, {tx_valid, tx_data}, {1'b1, prev_data});
            if (mode == 1 && cyc == 4) begin
                id_polynomial  = 17'h00000;
                id_iteration_0 = 17'h1FFFF;
                id_iteration_3 = 17'h00000;
            end
            case (mode)
                1:       rdy = cyc[0];
                2:       rdy = (got.size() == L - 1) ? (stall_cnt == TO - 1) : 1'b1;
                default: rdy = 1'b1;
            endcase
            tx_ready = rdy;
            if (tx_valid && rdy) got.push_back(tx_data);
            if (tx_valid && !rdy && got.size() == L - 1) stall_cnt++;
            stalled   = tx_valid && !rdy;
            prev_data = tx_data;
        end
        check({tag, "_released"}, id_reset, 1'b1);
        if (mode == 0) check({tag, "_cycles"}, cyc, L + 2);
        check({tag, "_len"}, got.size(), L);
        for (int i = 0; i < L && i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got[i], exp_frame[i]);
        repeat (3) step();
        check({tag, "_hold_idrst"}, {id_reset, busy, tx_valid}, 3'b110);
        id_ready = 1'b0;
        step();
        check({tag, "_idle"}, {id_reset, busy}, 2'b00);
        set_inputs();
        tx_ready = 1'b1;
    endtask

    task automatic do_timeout(output int n_high, output logic rel);
        int cyc = 0;
        n_high   = 0;
        id_ready = 1'b1;
        tx_ready = 1'b0;
        while (!id_reset && cyc < 100) begin
            step();
            cyc++;
            if (tx_valid) n_high++;
        end
        rel      = id_reset && !tx_valid;
        id_ready = 1'b0;
        step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        int   nh;
        logic rel;
        set_inputs();
        exp_frame = '{8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h01, 8'h00,
                      8'h00, 8'h02, 8'h00, 8'h00, 8'h03, 8'h01, 8'hFF, 8'hFF};
`ifdef ID_FRAME_CRC_EN
        exp_frame.push_back(crc_ref(exp_frame));
`endif

        reset = 1'b1;
        repeat (3) step();
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_id_reset", id_reset, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sent", frames_sent, 16'd0);
        check("rst_dropped", frames_dropped, 8'd0);
        reset = 1'b0;
        step();

        // reset in the middle of a frame
        id_ready = 1'b1;
        tx_ready = 1'b1;
        step();
        check("latch_cycle", {busy, tx_valid}, 2'b10);
        step();
        check("first_sync", {tx_valid, tx_data}, {1'b1, 8'hA5});
        repeat (5) step();
        check("mid_byte5", {tx_valid, tx_data}, {1'b1, exp_frame[5]});
        reset    = 1'b1;
        id_ready = 1'b0;
        step();
        reset = 1'b0;
        check("rstmid_outs", {tx_valid, busy, id_reset}, 3'b000);
        check("rstmid_sent", frames_sent, 16'd0);
        check("rstmid_dropped", frames_dropped, 8'd0);
        step();

        run_frame(0, "basic");
        check("basic_sent", frames_sent, 16'd1);
        check("basic_dropped", frames_dropped, 8'd0);

        run_frame(1, "bp");
        check("bp_sent", frames_sent, 16'd2);

        run_frame(2, "simult");
        check("simult_sent", frames_sent, 16'd3);
        check("simult_dropped", frames_dropped, 8'd0);

        do_timeout(nh, rel);
        check("to_valid_cycles", nh, TO);
        check("to_release", rel, 1'b1);
        check("to_dropped1", frames_dropped, 8'd1);
        repeat (253) do_timeout(nh, rel);
        check("to_dropped254", frames_dropped, 8'd254);
        repeat (46) do_timeout(nh, rel);
        check("to_dropped_sat", frames_dropped, 8'd255);
        check("to_sent_kept", frames_sent, 16'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
